// File: rtl/cla_app_accum_sched_pkg.sv
// Shared types and helpers for the accumulate scheduler: FSM encoding, datapath width, clog2.
package cla_app_accum_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // The shared adder is a fixed 16-bit instance; the datapath is tied to it.
  localparam int DW = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/carry_look_ahead_16bit.sv
// Approximate 16-bit adder: lower 12 bits are a carry-free OR, upper 4 bits are an exact
// lookahead adder whose carry-in is generated from bit 11.
module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign sum[11:0] = a[11:0] | b[11:0] | {11'b0, cin};

  assign p    = a[15:12] ^ b[15:12];
  assign g    = a[15:12] & b[15:12];
  assign c[0] = a[11] & b[11];
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum[15:12] = p ^ c[3:0];
  assign cout       = c[4];
endmodule

// File: rtl/cla_app_accum_sched_arb.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);
  always_comb begin
    int idx;
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx[IDW-1:0]]) begin
        any                 = 1'b1;
        gnt[idx[IDW-1:0]] = 1'b1;
        id                  = idx[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/cla_app_accum_sched.sv
// Round-robin scheduler sharing one approximate adder among NREQ burst requesters;
// accumulates a granted burst and returns the tagged sum with a sticky carry flag.
module cla_app_accum_sched
  import cla_app_accum_sched_pkg::*;
#(
  parameter int  NREQ = 4,
  parameter int  W    = DW,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_ovf
);
  state_t          state, nstate;
  logic [IDW-1:0]  rr_ptr, gnt, arb_id;
  logic [NREQ-1:0] gnt_oh, arb_gnt;
  logic            arb_any;
  logic [W-1:0]    acc, opd, sum;
  logic            ovf, cout, beat;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .gnt(arb_gnt), .id(arb_id), .any(arb_any)
  );

  // Operand mux keyed only on the latched grant, so idle lanes never reach the adder.
  assign opd  = req_data[int'(gnt)*W +: W];
  assign beat = (state == BUSY) && req_valid[gnt];

  carry_look_ahead_16bit u_add (
    .a(acc), .b(opd), .cin(1'b0), .sum(sum), .cout(cout)
  );

  always_comb begin
    nstate    = state;
    req_ready = '0;
    res_valid = 1'b0;
    case (state)
      IDLE: if (arb_any) nstate = BUSY;
      BUSY: begin
        req_ready = gnt_oh;
        if (beat && req_last[gnt]) nstate = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      gnt_oh <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: if (arb_any) begin
          gnt    <= arb_id;
          gnt_oh <= arb_gnt;
          acc    <= '0;
          ovf    <= 1'b0;
        end
        BUSY: if (beat) begin
          acc <= sum;
          ovf <= ovf | cout;
        end
        DONE: if (res_ready)
          rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign res_data = acc;
  assign res_id   = gnt;
  assign res_ovf  = ovf;
endmodule

// File: tb/tb_cla_app_accum_sched.sv
// Self-checking bench: burst scenarios and random bursts against a plain-arithmetic adder model.
module tb_cla_app_accum_sched;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_last  = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [W-1:0]    res_data;
  logic [1:0]      res_id;
  logic            res_ovf;

  int tests = 0;
  int errors = 0;

  logic [15:0] bq[$];
  logic [15:0] exp_s;
  logic        exp_o;
  logic [15:0] r_data;
  logic [1:0]  r_id;
  logic        r_ovf;

  typedef struct {int id; logic [15:0] s; logic o;} exp_t;

  cla_app_accum_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  // Golden adder: low 12 bits OR'ed, high nibble added exactly with carry from a[11]&b[11].
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [11:0] lo;
    int hi;
    lo = a[11:0] | b[11:0];
    hi = int'(a[15:12]) + int'(b[15:12]) + int'(a[11] & b[11]);
    return {hi[4:0], lo};
  endfunction

  task automatic model_burst();
    logic [16:0] r;
    exp_s = '0;
    exp_o = 1'b0;
    foreach (bq[i]) begin
      r = ref_add(exp_s, bq[i]);
      exp_s = r[15:0];
      exp_o = exp_o | r[16];
    end
  endtask

  task automatic drive_beat(input int id, input logic [15:0] d, input logic last);
    int cnt;
    req_valid[id] = 1'b1;
    req_data[id*W +: W] = d;
    req_last[id] = last;
    cnt = 0;
    while (!req_ready[id] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      tests++; errors++;
      $display("FAIL beat_timeout: req %0d ready=%b, required ready within 50 cycles", id, req_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_burst(input int id);
    model_burst();
    foreach (bq[i]) drive_beat(id, bq[i], i == bq.size() - 1);
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic collect_res();
    int cnt;
    cnt = 0;
    while (!res_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      tests++; errors++;
      $display("FAIL res_timeout: res_valid=%b, required 1 within 50 cycles", res_valid);
    end
    r_data = res_data; r_id = res_id; r_ovf = res_ovf;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ready, res_valid, res_data, res_id, res_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b valid=%b data=%h id=%0d ovf=%b, required all 0",
               req_ready, res_valid, res_data, res_id, res_ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    // Leave a result pending in DONE, then reset asynchronously between edges.
    bq = '{16'h0800, 16'h0001};
    send_burst(2);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({req_ready, res_valid, res_data, res_id, res_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_async: ready=%b valid=%b data=%h id=%0d ovf=%b, required all 0",
               req_ready, res_valid, res_data, res_id, res_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bq = '{16'h1000, 16'h2000, 16'h3000};
    send_burst(1);
    tests++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: res_valid=%b one cycle after last beat, required 1", res_valid);
    end
    collect_res();
    tests++;
    if (r_data !== 16'h6000 || r_data !== exp_s || r_id !== 2'd1 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_result: data=%h id=%0d ovf=%b, required data=6000 id=1 ovf=0",
               r_data, r_id, r_ovf);
    end
  endtask

  task automatic test_overflow();
    bq = '{16'hF000, 16'h2000};
    send_burst(0);
    collect_res();
    tests++;
    if (r_data !== 16'h1000 || r_data !== exp_s || r_id !== 2'd0 || r_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: data=%h id=%0d ovf=%b, required data=1000 id=0 ovf=1",
               r_data, r_id, r_ovf);
    end
    bq = '{16'h1000};
    send_burst(0);
    collect_res();
    tests++;
    if (r_data !== 16'h1000 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: data=%h ovf=%b, required data=1000 ovf=0", r_data, r_ovf);
    end
  endtask

  task automatic test_rr();
    int          beat[NREQ];
    int          nb[NREQ];
    logic [15:0] d[NREQ][2];
    logic [15:0] macc[NREQ];
    logic        movf[NREQ];
    logic        acc_f[NREQ];
    exp_t        eq[$];
    exp_t        e;
    int          ord[$];
    int          cyc;
    logic [16:0] r;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      beat[i] = 0; nb[i] = 0; macc[i] = '0; movf[i] = 1'b0;
      d[i][0] = 16'($urandom); d[i][1] = 16'($urandom);
    end
    cyc = 0;
    while (ord.size() < 8 && cyc < 400) begin
      tests++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL rr_onehot: req_ready=%b, required at most one bit set", req_ready);
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (nb[i] < 2);
        req_data[i*W +: W] = d[i][beat[i]];
        req_last[i] = (beat[i] == 1);
        acc_f[i] = req_valid[i] & req_ready[i];
      end
      res_ready = res_valid;
      if (res_valid) begin
        tests++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL rr_spurious: result id=%0d data=%h, required no result", res_id, res_data);
        end else begin
          e = eq.pop_front();
          if (res_data !== e.s || int'(res_id) !== e.id || res_ovf !== e.o) begin
            errors++;
            $display("FAIL rr_result: data=%h id=%0d ovf=%b, required data=%h id=%0d ovf=%b",
                     res_data, res_id, res_ovf, e.s, e.id, e.o);
          end
        end
        ord.push_back(int'(res_id));
      end
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) if (acc_f[i]) begin
        if (beat[i] == 0) begin macc[i] = '0; movf[i] = 1'b0; end
        r = ref_add(macc[i], d[i][beat[i]]);
        macc[i] = r[15:0];
        movf[i] = movf[i] | r[16];
        beat[i]++;
        if (beat[i] == 2) begin
          eq.push_back('{i, macc[i], movf[i]});
          beat[i] = 0;
          nb[i]++;
          d[i][0] = 16'($urandom); d[i][1] = 16'($urandom);
        end
      end
    end
    req_valid = '0; req_last = '0; res_ready = 1'b0;
    tests++;
    if (ord.size() != 8) begin
      errors++;
      $display("FAIL rr_count: %0d results, required 8", ord.size());
    end
    for (int k = 0; k < ord.size(); k++) begin
      tests++;
      if (ord[k] != k % NREQ) begin
        errors++;
        $display("FAIL rr_order: grant %0d went to %0d, required %0d", k, ord[k], k % NREQ);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [15:0] sd, hd;
    logic [1:0]  hid;
    logic        ho;
    bq = '{16'($urandom), 16'($urandom), 16'($urandom)};
    model_burst();
    drive_beat(2, bq[0], 1'b0);
    drive_beat(2, bq[1], 1'b0);
    req_valid[2] = 1'b0;
    sd = res_data;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 4'b0100 || res_data !== sd) begin
        errors++;
        $display("FAIL stall_hold: ready=%b acc=%h, required ready=0100 acc=%h", req_ready, res_data, sd);
      end
    end
    drive_beat(2, bq[2], 1'b1);
    req_valid[2] = 1'b0; req_last[2] = 1'b0;
    // Competing request while the result is back-pressured must not be granted.
    req_valid[3] = 1'b1;
    req_data[3*W +: W] = 16'h0123;
    req_last[3] = 1'b1;
    hd = res_data; hid = res_id; ho = res_ovf;
    repeat (5) begin
      tests++;
      if (res_valid !== 1'b1 || res_data !== hd || res_id !== hid || res_ovf !== ho || req_ready !== '0) begin
        errors++;
        $display("FAIL backpressure: valid=%b data=%h id=%0d ready=%b, required valid=1 data=%h id=%0d ready=0000",
                 res_valid, res_data, res_id, req_ready, hd, hid);
      end
      @(negedge clk);
    end
    collect_res();
    tests++;
    if (r_data !== exp_s || r_id !== 2'd2 || r_ovf !== exp_o) begin
      errors++;
      $display("FAIL stall_result: data=%h id=%0d ovf=%b, required data=%h id=2 ovf=%b",
               r_data, r_id, r_ovf, exp_s, exp_o);
    end
    bq = '{16'h0123};
    send_burst(3);
    collect_res();
    tests++;
    if (r_data !== exp_s || r_id !== 2'd3) begin
      errors++;
      $display("FAIL stall_next: data=%h id=%0d, required data=%h id=3", r_data, r_id, exp_s);
    end
  endtask

  task automatic test_reset_mid();
    drive_beat(1, 16'h4000, 1'b0);
    drive_beat(1, 16'h4000, 1'b0);
    #2 rst = 1'b1;
    #1;
    req_valid = '0; req_last = '0;
    tests++;
    if (req_ready !== '0 || res_valid !== 1'b0 || res_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b data=%h, required all 0", req_ready, res_valid, res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bq = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    send_burst(1);
    collect_res();
    tests++;
    if (r_data !== 16'h0000 || r_data !== exp_s || r_ovf !== 1'b1 || r_id !== 2'd1) begin
      errors++;
      $display("FAIL reset_resend: data=%h id=%0d ovf=%b, required data=0000 id=1 ovf=1",
               r_data, r_id, r_ovf);
    end
  endtask

  task automatic test_random();
    int id, n;
    for (int t = 0; t < 12; t++) begin
      id = $urandom_range(0, NREQ - 1);
      n  = $urandom_range(1, 4);
      bq = {};
      for (int k = 0; k < n; k++) bq.push_back(16'($urandom));
      for (int i = 0; i < NREQ; i++) if (i != id) req_data[i*W +: W] = 16'($urandom);
      send_burst(id);
      collect_res();
      tests++;
      if (r_data !== exp_s || int'(r_id) !== id || r_ovf !== exp_o) begin
        errors++;
        $display("FAIL random_burst: data=%h id=%0d ovf=%b, required data=%h id=%0d ovf=%b",
                 r_data, r_id, r_ovf, exp_s, id, exp_o);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_rr();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
